sequenciador_ula: RTL and testbench
===================================

Name: sequenciador_ula

Overview:
Sequential operand loader and result capture for the 4-bit ULA. One debounced pushbutton steps the user through entering A, then B, then the operation from the switches. The block drives the ULA's registered operand and selector inputs, pulses an execute strobe, and latches the ULA result and flags for display. It sits between the board switches/KEY and the ULA datapath, acting as the initiator side of the ULA operand/result interface.

Parameters:
WIDTH, 4, operand/result width in bits.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button level change (1 ms at 50 MHz; benches use 4).

Ports:
CLOCK_50  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
btn_n  input  1  raw KEY, active-low, asynchronous to the clock.
sw_dado  input  WIDTH  operand value sampled on a press in CARREGA_A or CARREGA_B.
sw_op  input  2  operation sampled on a press in CARREGA_OP (00 add, 01 sub, 10 AND, 11 OR).
op_a  output  WIDTH  registered operand A to the ULA.
op_b  output  WIDTH  registered operand B to the ULA.
seletor  output  2  registered operation selector to the ULA.
ula_valid  output  1  one-cycle execute strobe.
ula_resultado  input  WIDTH  ULA result; combinational from op_a, op_b and seletor.
ula_cout  input  1  ULA carry-out.
ula_ov  input  1  ULA signed overflow.
resultado  output  WIDTH  latched result.
flags  output  3  latched flags as {zero, ov, cout}.
estado  output  3  current FSM state code, for LEDs.
pronto  output  1  high while in MOSTRA.

Behaviour:
- Synchronizer: btn_n passes through 2 flip-flops to give s. Both reset to 1.
- Debounce: the debounced level deb resets to 1 and counter cnt resets to 0.
  - If s == deb, cnt is set to 0.
  - If s != deb and cnt == DEBOUNCE_CYCLES-1, deb takes s and cnt is set to 0.
  - Otherwise cnt increments.
- Press event: registered one-cycle pulse, raised on the edge after deb goes 1->0.
  - A held button gives exactly one press.
  - Release gives no event.
  - Any mismatch run shorter than DEBOUNCE_CYCLES is ignored.
- Press latency: with btn_n held low from edge 0, the press pulse is high in the cycle following edge DEBOUNCE_CYCLES+3.
- FSM states: CARREGA_A=000, CARREGA_B=001, CARREGA_OP=010, EXECUTA=011, MOSTRA=100.
  - CARREGA_A: on press, op_a <= sw_dado, go to CARREGA_B.
  - CARREGA_B: on press, op_b <= sw_dado, go to CARREGA_OP.
  - CARREGA_OP: on press, seletor <= sw_op, go to EXECUTA.
  - EXECUTA: lasts exactly 1 cycle and ignores presses.
    - ula_valid = 1 during this cycle.
    - On the exiting edge: resultado <= ula_resultado; zero <= (ula_resultado == 0); ov <= ula_ov & ~seletor[1]; cout <= ula_cout & ~seletor[1].
    - Logic ops always report ov = 0 and cout = 0.
    - Go to MOSTRA.
  - MOSTRA: pronto = 1 and resultado/flags are held. On press, go to CARREGA_A.
- Register retention: op_a, op_b, seletor, resultado and flags hold their values until overwritten by a later capture.
- Press timing: a press arriving in a cycle with no accepting state has no effect and is not queued.
- Outputs: ula_valid and pronto are decoded from the state register (glitch-free, no combinational path from inputs).
- Reset: takes effect on the next edge from any state, including mid-debounce and EXECUTA.
  - estado=000, op_a=op_b=0, seletor=00, resultado=0, flags=000, ula_valid=0, pronto=0, deb=1, cnt=0, press=0.
  - A press pulse coincident with reset is discarded.
- Arithmetic: all ULA arithmetic (mod 2^WIDTH, carry/overflow) belongs to the ULA. This block only samples it.

Test Plan (DEBOUNCE_CYCLES=4; ULA behavioural model attached):
1. Assert reset 2 cycles, then release -> estado=000, op_a=op_b=0, seletor=00, resultado=0, flags=000, ula_valid=0, pronto=0.
2. Button glitches and hold, with sw_dado=5:
   - btn_n low 3 cycles then high -> no press, estado stays 000.
   - btn_n low 40 cycles -> exactly one press; op_a=5, estado=001.
3. Add with wrap: A=7, B=9, sw_op=00 (four presses) -> ula_valid high exactly 1 cycle, then estado=100, pronto=1, resultado=0, flags=101 (zero=1, ov=0, cout=1).
4. Subtract: A=3, B=5, sw_op=01 -> resultado=14, flags=000. Separately A=8, B=1, sw_op=01 -> resultado=7, flags=011 (signed overflow, no borrow).
5. AND with forced flags: A=12, B=10, sw_op=10, model forcing ula_cout=1 and ula_ov=1 -> resultado=8, flags=000. Next press -> estado=000, resultado still 8.
6. Reset mid-operation: reset asserted while in CARREGA_OP, with a press pulse coincident -> next edge estado=000, op_a=0, seletor=00, no ula_valid ever asserted.

Source files
------------

// File: rtl/sequenciador_ula.sv
// sequenciador_ula: steps the user through entering operand A, operand B and
// the operation with one pushbutton, drives the ULA and latches its result.
//
// state      | meaning
// CARREGA_A  | waiting for a press to capture operand A
// CARREGA_B  | waiting for a press to capture operand B
// CARREGA_OP | waiting for a press to capture the operation selector
// EXECUTA    | one-cycle execute strobe, result captured on exit
// MOSTRA     | result and flags shown; a press starts over
module sequenciador_ula #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             btn_n,
  input  logic [WIDTH-1:0] sw_dado,
  input  logic [1:0]       sw_op,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [1:0]       seletor,
  output logic             ula_valid,
  input  logic [WIDTH-1:0] ula_resultado,
  input  logic             ula_cout,
  input  logic             ula_ov,
  output logic [WIDTH-1:0] resultado,
  output logic [2:0]       flags,
  output logic [2:0]       estado,
  output logic             pronto
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    CARREGA_A  = 3'b000,
    CARREGA_B  = 3'b001,
    CARREGA_OP = 3'b010,
    EXECUTA    = 3'b011,
    MOSTRA     = 3'b100
  } estado_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  estado_t          r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [1:0]       r_seletor;
  logic [WIDTH-1:0] r_resultado;
  logic [2:0]       r_flags;

  logic w_zero;
  logic w_ov;
  logic w_cout;

  // Two-flop synchronizer for the asynchronous KEY; idles released (high).
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after it has differed for the full window.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_deb <= 1'b1;
      r_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Registered one-cycle press pulse on the debounced 1->0 transition only.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_deb_d <= r_deb;
      r_press <= r_deb_d & ~r_deb;
    end
  end

  // Logic operations never report carry or overflow, whatever the ULA drives.
  assign w_zero = (ula_resultado == '0);
  assign w_ov   = ula_ov & ~r_seletor[1];
  assign w_cout = ula_cout & ~r_seletor[1];

  // Sequencing FSM with its captured operand/result registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= CARREGA_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_seletor   <= 2'b00;
      r_resultado <= '0;
      r_flags     <= 3'b000;
    end else begin
      case (r_state)
        CARREGA_A: begin
          if (r_press) begin
            r_op_a  <= sw_dado;
            r_state <= CARREGA_B;
          end
        end
        CARREGA_B: begin
          if (r_press) begin
            r_op_b  <= sw_dado;
            r_state <= CARREGA_OP;
          end
        end
        CARREGA_OP: begin
          if (r_press) begin
            r_seletor <= sw_op;
            r_state   <= EXECUTA;
          end
        end
        EXECUTA: begin
          r_resultado <= ula_resultado;
          r_flags     <= {w_zero, w_ov, w_cout};
          r_state     <= MOSTRA;
        end
        MOSTRA: begin
          if (r_press) begin
            r_state <= CARREGA_A;
          end
        end
        default: r_state <= CARREGA_A;
      endcase
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign seletor   = r_seletor;
  assign resultado = r_resultado;
  assign flags     = r_flags;
  assign estado    = r_state;
  assign ula_valid = (r_state == EXECUTA);
  assign pronto    = (r_state == MOSTRA);

endmodule

// File: tb/tb_sequenciador_ula.sv
// Bench for sequenciador_ula with a behavioural ULA and a result scoreboard.
module tb_sequenciador_ula;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_n;
  logic [WIDTH-1:0] sw_dado;
  logic [1:0]       sw_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       seletor;
  logic             ula_valid;
  logic [WIDTH-1:0] ula_resultado;
  logic             ula_cout;
  logic             ula_ov;
  logic [WIDTH-1:0] resultado;
  logic [2:0]       flags;
  logic [2:0]       estado;
  logic             pronto;

  logic             force_flags;
  int               checks   = 0;
  int               failures = 0;
  int               valid_cnt;
  logic             pronto_d;
  logic [6:0]       exp_q[$];

  sequenciador_ula #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .btn_n         (btn_n),
    .sw_dado       (sw_dado),
    .sw_op         (sw_op),
    .op_a          (op_a),
    .op_b          (op_b),
    .seletor       (seletor),
    .ula_valid     (ula_valid),
    .ula_resultado (ula_resultado),
    .ula_cout      (ula_cout),
    .ula_ov        (ula_ov),
    .resultado     (resultado),
    .flags         (flags),
    .estado        (estado),
    .pronto        (pronto)
  );

  always #5 clk = ~clk;

  // Behavioural ULA: add/sub with carry (no-borrow for sub) and signed overflow.
  always_comb begin
    logic [4:0] t;
    t             = '0;
    ula_resultado = '0;
    ula_cout      = 1'b0;
    ula_ov        = 1'b0;
    case (seletor)
      2'b00: begin
        t             = {1'b0, op_a} + {1'b0, op_b};
        ula_resultado = t[3:0];
        ula_cout      = t[4];
        ula_ov        = (op_a[3] == op_b[3]) && (t[3] != op_a[3]);
      end
      2'b01: begin
        t             = {1'b0, op_a} + {1'b0, ~op_b} + 5'd1;
        ula_resultado = t[3:0];
        ula_cout      = t[4];
        ula_ov        = (op_a[3] != op_b[3]) && (t[3] != op_a[3]);
      end
      2'b10: begin
        ula_resultado = op_a & op_b;
        ula_cout      = force_flags;
        ula_ov        = force_flags;
      end
      default: begin
        ula_resultado = op_a | op_b;
        ula_cout      = force_flags;
        ula_ov        = force_flags;
      end
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Monitor: count execute strobes and score each result when MOSTRA is entered.
  always @(negedge clk) begin
    if (ula_valid === 1'b1) valid_cnt++;
    if (pronto === 1'b1 && pronto_d !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_result", 1, 0);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check_val("sb_resultado", resultado, e[6:3]);
        check_val("sb_flags", flags, e[2:0]);
      end
    end
    pronto_d = pronto;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press();
    btn_n = 1'b0;
    tick(12);
    btn_n = 1'b1;
    tick(12);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                        input logic [3:0] exp_res, input logic [2:0] exp_flags);
    exp_q.push_back({exp_res, exp_flags});
    valid_cnt = 0;
    sw_dado = a;
    do_press();
    sw_dado = b;
    do_press();
    sw_op = op;
    do_press();
    check_val("valid_pulses", valid_cnt, 1);
    check_val("estado_mostra", estado, 3'b100);
    check_val("pronto_mostra", pronto, 1);
    check_val("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset       = 1'b1;
    btn_n       = 1'b1;
    sw_dado     = '0;
    sw_op       = 2'b00;
    force_flags = 1'b0;
    valid_cnt   = 0;
    pronto_d    = 1'b0;

    // 1. reset state
    tick(2);
    reset = 1'b0;
    tick(1);
    check_val("rst_estado", estado, 0);
    check_val("rst_op_a", op_a, 0);
    check_val("rst_op_b", op_b, 0);
    check_val("rst_seletor", seletor, 0);
    check_val("rst_resultado", resultado, 0);
    check_val("rst_flags", flags, 0);
    check_val("rst_valid", ula_valid, 0);
    check_val("rst_pronto", pronto, 0);

    // 2. glitch shorter than the window, then a long hold
    sw_dado = 4'd5;
    btn_n = 1'b0;
    tick(3);
    btn_n = 1'b1;
    tick(15);
    check_val("glitch_estado", estado, 0);
    check_val("glitch_op_a", op_a, 0);
    btn_n = 1'b0;
    tick(40);
    btn_n = 1'b1;
    tick(15);
    check_val("hold_op_a", op_a, 5);
    check_val("hold_estado", estado, 1);
    do_reset(2);
    check_val("rst2_estado", estado, 0);

    // 3. add with wrap
    run_op(4'd7, 4'd9, 2'b00, 4'd0, 3'b101);
    do_press();
    check_val("add_back_estado", estado, 0);

    // 4. subtract
    run_op(4'd3, 4'd5, 2'b01, 4'd14, 3'b000);
    do_press();
    run_op(4'd8, 4'd1, 2'b01, 4'd7, 3'b011);
    do_press();

    // 5. AND with the ULA forcing carry/overflow high
    force_flags = 1'b1;
    run_op(4'd12, 4'd10, 2'b10, 4'd8, 3'b000);
    do_press();
    force_flags = 1'b0;
    check_val("and_back_estado", estado, 0);
    check_val("and_hold_resultado", resultado, 8);

    // 6. reset in CARREGA_OP landing on the same edge as a press pulse
    sw_dado = 4'd6;
    do_press();
    sw_dado = 4'd2;
    do_press();
    check_val("pre_rst_estado", estado, 2);
    valid_cnt = 0;
    sw_op = 2'b11;
    btn_n = 1'b0;
    tick(7);
    reset = 1'b1;
    btn_n = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("midrst_estado", estado, 0);
    check_val("midrst_op_a", op_a, 0);
    check_val("midrst_seletor", seletor, 0);
    tick(20);
    check_val("midrst_no_valid", valid_cnt, 0);
    check_val("midrst_estado_late", estado, 0);
    check_val("sb_final_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
